// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store access unit between the execute stage and the
// data memory. It accepts one request at a time, drives word address, byte
// enables and lane-replicated store data, waits out the read latency, and
// returns the extracted, extended load result with a one-cycle valid pulse.
module mem_access_unit #(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        mem_write,
  input  logic [2:0]        mask,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              dmem_en,
  output logic [3:0]        dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] CNT_INIT = 3'(RD_LATENCY - 1);

  state_t      state;
  logic [2:0]  cnt;
  logic [1:0]  mw_r;
  logic [2:0]  mask_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        err_r;

  // Misaligned halves/words and undefined load types are rejected.
  function automatic logic req_error(input logic [1:0] mw, input logic [2:0] mk,
                                     input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    unique case (mw)
      2'b00: begin
        case (mk)
          3'b000, 3'b011: bad = 1'b0;
          3'b001, 3'b100: bad = off[0];
          3'b010:         bad = (off != 2'b00);
          default:        bad = 1'b1;
        endcase
      end
      2'b01: bad = 1'b0;
      2'b10: bad = off[0];
      2'b11: bad = (off != 2'b00);
    endcase
    return bad;
  endfunction

  // Big-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] load_extend(input logic [2:0] mk, input logic [1:0] off,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    unique case (off)
      2'd0: b = rd[31:24];
      2'd1: b = rd[23:16];
      2'd2: b = rd[15:8];
      2'd3: b = rd[7:0];
    endcase
    h = off[1] ? rd[15:0] : rd[31:16];
    case (mk)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b011:  res = {24'b0, b};
      3'b100:  res = {16'b0, h};
      default: res = rd;
    endcase
    return res;
  endfunction

  // Request FSM: capture, issue, wait out read latency, respond.
  // Errored requests still pass through ISSUE (with dmem_en suppressed) so the
  // error response lands two cycles after acceptance like a store.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mw_r      <= '0;
      mask_r    <= '0;
      addr_r    <= '0;
      wdata_r   <= '0;
      err_r     <= 1'b0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            mw_r      <= mem_write;
            mask_r    <= mask;
            addr_r    <= addr;
            wdata_r   <= wdata;
            err_r     <= req_error(mem_write, mask, addr[1:0]);
            resp_err  <= req_error(mem_write, mask, addr[1:0]);
            resp_data <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (err_r) begin
            state <= RESP;
          end else if (dmem_ready) begin
            if (mw_r == 2'b00) begin
              cnt   <= CNT_INIT;
              state <= WAIT;
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            resp_data <= load_extend(mask_r, addr_r[1:0], dmem_rdata);
            state     <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          resp_data <= '0;
          resp_err  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign dmem_en    = (state == ISSUE) && !err_r;
  assign dmem_addr  = addr_r[ADDR_W+1:2];

  // Byte enables and replicated store data decoded from the registered request.
  always_comb begin
    // NOTE: defaults first so no path through this block infers a latch.
    dmem_we    = 4'b0000;
    dmem_wdata = 32'h0;
    unique case (mw_r)
      2'b00: dmem_wdata = 32'h0;
      2'b01: begin
        dmem_wdata = {4{wdata_r[7:0]}};
        if (dmem_en) dmem_we = 4'b1000 >> addr_r[1:0];
      end
      2'b10: begin
        dmem_wdata = {2{wdata_r[15:0]}};
        if (dmem_en) dmem_we = addr_r[1] ? 4'b0011 : 4'b1100;
      end
      2'b11: begin
        dmem_wdata = wdata_r;
        if (dmem_en) dmem_we = 4'b1111;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: two instances (read latency 1 and 3) share
// request and memory inputs; each is checked against a byte-level reference
// model for data, enables, timing and error behaviour.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [1:0]  mem_write;
  logic [2:0]  mask;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        dmem_ready;
  logic [31:0] rd_val;

  logic        rdy_o  [2];
  logic        en_o   [2];
  logic [3:0]  we_o   [2];
  logic [29:0] addr_o [2];
  logic [31:0] wd_o   [2];
  logic        rv_o   [2];
  logic [31:0] rdat_o [2];
  logic        rerr_o [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.RD_LATENCY(1), .ADDR_W(30)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_o[0]),
    .mem_write(mem_write), .mask(mask), .addr(addr), .wdata(wdata),
    .dmem_en(en_o[0]), .dmem_we(we_o[0]), .dmem_addr(addr_o[0]), .dmem_wdata(wd_o[0]),
    .dmem_ready(dmem_ready), .dmem_rdata(rd_val),
    .resp_valid(rv_o[0]), .resp_data(rdat_o[0]), .resp_err(rerr_o[0]));

  mem_access_unit #(.RD_LATENCY(3), .ADDR_W(30)) dut_l3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_o[1]),
    .mem_write(mem_write), .mask(mask), .addr(addr), .wdata(wdata),
    .dmem_en(en_o[1]), .dmem_we(we_o[1]), .dmem_addr(addr_o[1]), .dmem_wdata(wd_o[1]),
    .dmem_ready(dmem_ready), .dmem_rdata(rd_val),
    .resp_valid(rv_o[1]), .resp_data(rdat_o[1]), .resp_err(rerr_o[1]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    else n_pass++;
  endtask

  // Reference: access size in bytes, alignment by modulo, lanes by shifting.
  function automatic void ref_model(input logic [1:0] mw, input logic [2:0] mk,
                                    input logic [31:0] ad, input logic [31:0] wd,
                                    input logic [31:0] rd, output logic err,
                                    output logic [31:0] data, output logic [3:0] we,
                                    output logic [31:0] wdo);
    int size, off, sh;
    logic [31:0] m, raw;
    off = int'(ad[1:0]);
    if (mw == 2'b00) begin
      case (mk)
        3'd0, 3'd3: size = 1;
        3'd1, 3'd4: size = 2;
        3'd2:       size = 4;
        default:    size = 0;
      endcase
    end else begin
      size = (mw == 2'b01) ? 1 : (mw == 2'b10) ? 2 : 4;
    end
    err  = (size == 0) || (off % size != 0);
    data = 32'h0;
    we   = 4'h0;
    wdo  = 32'h0;
    if (!err) begin
      sh = 8 * (4 - off - size);
      if (mw != 2'b00) begin
        we = 4'(((1 << size) - 1) << (4 - off - size));
        for (int i = 0; i < 4; i++) wdo[8*i +: 8] = wd[8*(i % size) +: 8];
      end else begin
        m   = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        raw = (rd >> sh) & m;
        if ((mk == 3'd0 || mk == 3'd1) && raw[8*size-1]) raw = raw | ~m;
        data = raw;
      end
    end
  endfunction

  task automatic check_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s[%0d] req_ready", tag, d), 32'(rdy_o[d]), 32'd1);
      check($sformatf("%s[%0d] dmem_en", tag, d), 32'(en_o[d]), 32'd0);
      check($sformatf("%s[%0d] dmem_we", tag, d), 32'(we_o[d]), 32'd0);
      check($sformatf("%s[%0d] dmem_addr", tag, d), 32'(addr_o[d]), 32'd0);
      check($sformatf("%s[%0d] dmem_wdata", tag, d), wd_o[d], 32'd0);
      check($sformatf("%s[%0d] resp_valid", tag, d), 32'(rv_o[d]), 32'd0);
      check($sformatf("%s[%0d] resp_data", tag, d), rdat_o[d], 32'd0);
      check($sformatf("%s[%0d] resp_err", tag, d), 32'(rerr_o[d]), 32'd0);
    end
  endtask

  // One request: accepted at cycle 0, observed for cycles 1..12 at negedge.
  task automatic run_txn(input string nm, input logic [1:0] mw, input logic [2:0] mk,
                         input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rd,
                         input int stall, input bit inject, input logic exp_err,
                         input logic [31:0] exp_data, input logic [3:0] exp_we,
                         input logic [31:0] exp_wd);
    int          lat [2];
    int          rcnt[2];
    int          en_cnt[2];
    bit          unstable[2];
    logic [31:0] got_data[2];
    logic        got_err[2];
    logic [3:0]  cap_we[2];
    logic [29:0] cap_addr[2];
    logic [31:0] cap_wd[2];
    int          exp_lat;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s[%0d] ready_before", nm, d), 32'(rdy_o[d]), 32'd1);
      lat[d] = -1; rcnt[d] = 0; en_cnt[d] = 0; unstable[d] = 1'b0;
      got_data[d] = 32'h0; got_err[d] = 1'b0;
      cap_we[d] = '0; cap_addr[d] = '0; cap_wd[d] = '0;
    end
    mem_write  = mw;
    mask       = mk;
    addr       = ad;
    wdata      = wd;
    rd_val     = rd;
    req_valid  = 1'b1;
    dmem_ready = (stall == 0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      req_valid  = inject && (k == 2);
      if (inject && k == 2) begin
        mem_write = 2'b01; addr = 32'h0000_0200; wdata = 32'h0;
      end
      dmem_ready = (k > stall);
      for (int d = 0; d < 2; d++) begin
        if (rv_o[d]) begin
          rcnt[d]++;
          if (lat[d] < 0) begin
            lat[d] = k; got_data[d] = rdat_o[d]; got_err[d] = rerr_o[d];
          end
        end
        if (en_o[d]) begin
          if (en_cnt[d] == 0) begin
            cap_we[d] = we_o[d]; cap_addr[d] = addr_o[d]; cap_wd[d] = wd_o[d];
          end else if (we_o[d] !== cap_we[d] || addr_o[d] !== cap_addr[d] ||
                       wd_o[d] !== cap_wd[d]) begin
            unstable[d] = 1'b1;
          end
          en_cnt[d]++;
        end
      end
    end
    req_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      exp_lat = exp_err ? 2 : 2 + stall + ((mw == 2'b00) ? lat_of(d) : 0);
      check($sformatf("%s[%0d] resp_cycle", nm, d), 32'(lat[d]), 32'(exp_lat));
      check($sformatf("%s[%0d] resp_pulses", nm, d), 32'(rcnt[d]), 32'd1);
      check($sformatf("%s[%0d] resp_err", nm, d), 32'(got_err[d]), 32'(exp_err));
      check($sformatf("%s[%0d] resp_data", nm, d), got_data[d], exp_data);
      if (exp_err) begin
        check($sformatf("%s[%0d] en_cycles", nm, d), 32'(en_cnt[d]), 32'd0);
      end else begin
        check($sformatf("%s[%0d] en_cycles", nm, d), 32'(en_cnt[d]), 32'(stall + 1));
        check($sformatf("%s[%0d] dmem_addr", nm, d), 32'(cap_addr[d]), 32'(ad[31:2]));
        check($sformatf("%s[%0d] dmem_we", nm, d), 32'(cap_we[d]), 32'(exp_we));
        check($sformatf("%s[%0d] held_stable", nm, d), 32'(unstable[d]), 32'd0);
        if (mw != 2'b00)
          check($sformatf("%s[%0d] dmem_wdata", nm, d), cap_wd[d], exp_wd);
      end
    end
  endtask

  typedef struct {
    string       nm;
    logic [1:0]  mw;
    logic [2:0]  mk;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] rd;
    int          stall;
    bit          inject;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [3:0]  exp_we;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic        m_err;
    logic [31:0] m_data, m_wd, r_ad, r_wd, r_rd;
    logic [3:0]  m_we;
    logic [1:0]  r_mw;
    logic [2:0]  r_mk;
    int          r_st;

    vecs[0]  = '{"sb_102",     2'b01, 3'd0, 32'h102, 32'h1234_56AB, 32'h0,         0, 0, 1'b0, 32'h0,         4'b0010, 32'hABAB_ABAB};
    vecs[1]  = '{"lb_103",     2'b00, 3'd0, 32'h103, 32'h0,         32'h1122_3380, 0, 0, 1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0};
    vecs[2]  = '{"lbu_103",    2'b00, 3'd3, 32'h103, 32'h0,         32'h1122_3380, 0, 0, 1'b0, 32'h0000_0080, 4'b0000, 32'h0};
    vecs[3]  = '{"lh_100",     2'b00, 3'd1, 32'h100, 32'h0,         32'h8001_7FFF, 0, 0, 1'b0, 32'hFFFF_8001, 4'b0000, 32'h0};
    vecs[4]  = '{"lhu_102",    2'b00, 3'd4, 32'h102, 32'h0,         32'h8001_7FFF, 0, 0, 1'b0, 32'h0000_7FFF, 4'b0000, 32'h0};
    vecs[5]  = '{"lw_mis_102", 2'b00, 3'd2, 32'h102, 32'h0,         32'hFFFF_FFFF, 0, 0, 1'b1, 32'h0,         4'b0000, 32'h0};
    vecs[6]  = '{"sh_mis_101", 2'b10, 3'd0, 32'h101, 32'hFFFF_FFFF, 32'h0,         0, 0, 1'b1, 32'h0,         4'b0000, 32'h0};
    vecs[7]  = '{"mask_110",   2'b00, 3'd6, 32'h100, 32'h0,         32'hFFFF_FFFF, 0, 0, 1'b1, 32'h0,         4'b0000, 32'h0};
    vecs[8]  = '{"sw_stall3",  2'b11, 3'd0, 32'h104, 32'hDEAD_BEEF, 32'h0,         3, 1, 1'b0, 32'h0,         4'b1111, 32'hDEAD_BEEF};
    vecs[9]  = '{"sh_102",     2'b10, 3'd0, 32'h102, 32'h0000_CAFE, 32'h0,         0, 0, 1'b0, 32'h0,         4'b0011, 32'hCAFE_CAFE};
    vecs[10] = '{"lw_108",     2'b00, 3'd2, 32'h108, 32'h0,         32'h89AB_CDEF, 0, 0, 1'b0, 32'h89AB_CDEF, 4'b0000, 32'h0};
    vecs[11] = '{"sb_100_st1", 2'b01, 3'd0, 32'h100, 32'h0000_005A, 32'h0,         1, 0, 1'b0, 32'h0,         4'b1000, 32'h5A5A_5A5A};
    vecs[12] = '{"lb_101_pos", 2'b00, 3'd0, 32'h101, 32'h0,         32'h007F_0000, 0, 0, 1'b0, 32'h0000_007F, 4'b0000, 32'h0};
    vecs[13] = '{"lhu_mis",    2'b00, 3'd4, 32'h101, 32'h0,         32'h1234_5678, 0, 0, 1'b1, 32'h0,         4'b0000, 32'h0};
    vecs[14] = '{"sw_mis_101", 2'b11, 3'd0, 32'h101, 32'h1111_1111, 32'h0,         0, 0, 1'b1, 32'h0,         4'b0000, 32'h0};

    rst_n = 1'b0; req_valid = 1'b0; mem_write = 2'b00; mask = 3'd0;
    addr = 32'h0; wdata = 32'h0; dmem_ready = 1'b1; rd_val = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    foreach (vecs[i])
      run_txn(vecs[i].nm, vecs[i].mw, vecs[i].mk, vecs[i].ad, vecs[i].wd, vecs[i].rd,
              vecs[i].stall, vecs[i].inject, vecs[i].exp_err, vecs[i].exp_data,
              vecs[i].exp_we, vecs[i].exp_wd);

    // Reset while both instances wait on read data.
    @(negedge clk);
    mem_write = 2'b00; mask = 3'd2; addr = 32'h100; rd_val = 32'h1357_9BDF;
    req_valid = 1'b1; dmem_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_wait en_low", 32'(en_o[1]), 32'd0);
    check("rst_wait busy", 32'(rdy_o[1]), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset("rst_wait");
    begin
      int pulses = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (rv_o[0] || rv_o[1]) pulses++;
      end
      check("rst_wait no_resp", 32'(pulses), 32'd0);
    end

    // Randomized requests against the reference model.
    for (int n = 0; n < 40; n++) begin
      r_mw = 2'($urandom_range(0, 3));
      r_mk = 3'($urandom_range(0, 7));
      r_ad = $urandom;
      r_wd = $urandom;
      r_rd = $urandom;
      r_st = $urandom_range(0, 2);
      ref_model(r_mw, r_mk, r_ad, r_wd, r_rd, m_err, m_data, m_we, m_wd);
      run_txn($sformatf("rnd%0d", n), r_mw, r_mk, r_ad, r_wd, r_rd, r_st, 1'b0,
              m_err, m_data, m_we, m_wd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
